// File: rtl/c_pkg.sv
// Shared definitions for the c_unary_enc streaming unary (thermometer) encoder.
// Contents:
//   c_unary_enc_cnt_w(w) - width of a count port able to carry 0..w
//   C_UNARY_CNT_MAX_W    - width of the count field held in the S1 record
//   c_unary_s1_t         - S1 pipeline record {cnt, ok}
//   C_UNARY_ERR_CNT_W    - width of the optional saturating error counter
package c_pkg;

  function automatic int c_unary_enc_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Wide enough for any realistic vector width; the top zero-extends into it.
  localparam int C_UNARY_CNT_MAX_W = 16;

  localparam int C_UNARY_ERR_CNT_W = 16;

  typedef struct packed {
    logic [C_UNARY_CNT_MAX_W-1:0] cnt;
    logic                         ok;   // count was in the legal range 1..W-1
  } c_unary_s1_t;

endpackage

// File: rtl/c_unary_enc_stage.sv
// Generic valid/ready pipeline register slot.
// Ports:
//   clk     clock
//   rst     synchronous, active-high reset
//   i_adv   slot may be overwritten this cycle (empty or being drained)
//   i_vld   incoming entry is valid
//   i_data  incoming entry payload
//   o_vld   slot holds a valid entry
//   o_data  slot payload; only rewritten by a valid load, so it holds while stalled
module c_unary_enc_stage #(
  parameter int              P_DW      = 8,
  parameter logic [P_DW-1:0] P_RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_adv,
  input  logic            i_vld,
  input  logic [P_DW-1:0] i_data,
  output logic            o_vld,
  output logic [P_DW-1:0] o_data
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld  <= 1'b0;
      o_data <= P_RST_VAL;
    end else if (i_adv) begin
      // Advancing with no incoming entry empties the slot.
      o_vld <= i_vld;
      if (i_vld) o_data <= i_data;
    end
  end

endmodule

// File: rtl/c_unary_enc.sv
// Streaming unary (thermometer) encoder: count N in, W-bit vector with bits
// [N-1:0] set out (inverted when P_IS_COMPLIMENT=1). Two-stage pipeline:
// S1 holds {N, range ok}, S2 holds the generated vector. Out-of-range counts
// are accepted, carried through S1 and dropped there with a one-cycle o_err.
// Optional feature macro: C_UNARY_ENC_ERR_CNT_EN adds o_err_cnt.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   i_in_vld, i_in_cnt   input count handshake (valid / count N)
//   o_in_rdy             input ready
//   o_out_vld, o_out_x   output vector handshake (valid / vector)
//   i_out_rdy            output ready
//   o_err                pulse when an illegal count leaves S1
//   o_err_cnt            saturating count of o_err pulses (macro only)
module c_unary_enc
  import c_pkg::*;
#(
  parameter int P_W             = 8,
  parameter int P_IS_COMPLIMENT = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_in_vld,
  input  logic [c_unary_enc_cnt_w(P_W)-1:0] i_in_cnt,
  output logic                          o_in_rdy,
  output logic                          o_out_vld,
  output logic [P_W-1:0]                o_out_x,
  input  logic                          i_out_rdy,
  output logic                          o_err
`ifdef C_UNARY_ENC_ERR_CNT_EN
  ,
  output logic [C_UNARY_ERR_CNT_W-1:0]  o_err_cnt
`endif
);

  localparam int CW = c_unary_enc_cnt_w(P_W);
  localparam logic [P_W-1:0] RST_X = (P_IS_COMPLIMENT != 0) ? {P_W{1'b1}} : '0;

  logic        s1_vld;
  c_unary_s1_t s1_d;
  c_unary_s1_t s1_q;
  logic        s1_adv;
  logic        s2_adv;
  logic        s2_load;
  logic [P_W-1:0] gen_x;

  assign s2_adv   = ~o_out_vld | i_out_rdy;
  assign s1_adv   = s1_vld & s2_adv;
  assign o_in_rdy = ~s1_vld | s2_adv;

  // Illegal entries leave S1 without writing S2, so S2 empties behind them.
  assign s2_load = s1_vld & s1_q.ok;
  assign o_err   = s1_adv & ~s1_q.ok;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    s1_d     = '0;
    s1_d.cnt = C_UNARY_CNT_MAX_W'(i_in_cnt);
    s1_d.ok  = (i_in_cnt != '0) && (i_in_cnt < CW'(P_W));
    // (1<<N)-1 at width W+1 so N=W would not overflow before truncation.
    gen_x = P_W'(((P_W + 1)'(1) << s1_q.cnt) - (P_W + 1)'(1));
    if (P_IS_COMPLIMENT != 0) gen_x = ~gen_x;
  end

  c_unary_enc_stage #(
    .P_DW      ($bits(c_unary_s1_t)),
    .P_RST_VAL ('0)
  ) u_s1 (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (o_in_rdy),
    .i_vld  (i_in_vld),
    .i_data (s1_d),
    .o_vld  (s1_vld),
    .o_data (s1_q)
  );

  c_unary_enc_stage #(
    .P_DW      (P_W),
    .P_RST_VAL (RST_X)
  ) u_s2 (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (s2_adv),
    .i_vld  (s2_load),
    .i_data (gen_x),
    .o_vld  (o_out_vld),
    .o_data (o_out_x)
  );

`ifdef C_UNARY_ENC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err_cnt <= '0;
    end else if (o_err && (o_err_cnt != '1)) begin
      o_err_cnt <= o_err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_c_unary_enc.sv
// Scoreboard bench for c_unary_enc at P_W=8. Two instances share stimulus:
// dut (true code) and dut_c (compliment code). Senders push the hand-computed
// vector on acceptance; a monitor pops and compares on every output transfer.
module tb_c_unary_enc;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_in_vld;
  logic [CW-1:0] i_in_cnt;
  logic          i_out_rdy;
  logic          o_in_rdy, o_out_vld, o_err;
  logic [W-1:0]  o_out_x;
  logic          c_in_rdy, c_out_vld, c_err;
  logic [W-1:0]  c_out_x;
`ifdef C_UNARY_ENC_ERR_CNT_EN
  logic [15:0]   o_err_cnt, c_err_cnt;
`endif

  always #5 clk = ~clk;

  c_unary_enc #(.P_W(W), .P_IS_COMPLIMENT(0)) dut (
    .clk(clk), .rst(rst), .i_in_vld(i_in_vld), .i_in_cnt(i_in_cnt),
    .o_in_rdy(o_in_rdy), .o_out_vld(o_out_vld), .o_out_x(o_out_x),
    .i_out_rdy(i_out_rdy), .o_err(o_err)
`ifdef C_UNARY_ENC_ERR_CNT_EN
    , .o_err_cnt(o_err_cnt)
`endif
  );

  c_unary_enc #(.P_W(W), .P_IS_COMPLIMENT(1)) dut_c (
    .clk(clk), .rst(rst), .i_in_vld(i_in_vld), .i_in_cnt(i_in_cnt),
    .o_in_rdy(c_in_rdy), .o_out_vld(c_out_vld), .o_out_x(c_out_x),
    .i_out_rdy(i_out_rdy), .o_err(c_err)
`ifdef C_UNARY_ENC_ERR_CNT_EN
    , .o_err_cnt(c_err_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int err_seen = 0;
  int exp_err  = 0;
  logic [W-1:0] exp_q[$];
  int           out_cyc[$];

  // Hand-computed thermometer table for N = 0..8 (0 and 8 never pushed).
  logic [W-1:0] therm [0:8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                                8'h1F, 8'h3F, 8'h7F, 8'hFF};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a transfer happens on the coming edge when vld & rdy now.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_err) err_seen++;
      check("compl_vld_match", {31'b0, c_out_vld}, {31'b0, o_out_vld});
      if (o_out_vld && i_out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {24'b0, o_out_x}, 32'hDEAD);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("out_x", {24'b0, o_out_x}, {24'b0, e});
          check("out_x_compl", {24'b0, c_out_x}, {24'b0, ~e});
          out_cyc.push_back(cyc);
        end
      end
    end
  end

  // Present count n and hold it until accepted (ready seen before the edge).
  task automatic send(input int n);
    logic r;
    int   k;
    i_in_vld = 1'b1;
    i_in_cnt = CW'(n);
    k = 0;
    do begin
      @(negedge clk);
      r = o_in_rdy;
      @(posedge clk);
      k++;
    end while (!r && k < 100);
    if (!r) check("send_timeout", 32'(k), 0);
    if (n >= 1 && n < W) exp_q.push_back(therm[n]);
    else exp_err++;
    acc_cnt++;
    #1;
    i_in_vld = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || o_out_vld) && k < 60) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_done", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_in_vld = 1'b0; i_in_cnt = '0; i_out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_in_rdy",  {31'b0, o_in_rdy},  1);
    check("rst_out_vld", {31'b0, o_out_vld}, 0);
    check("rst_out_x",   {24'b0, o_out_x},   0);
    check("rst_out_x_c", {24'b0, c_out_x},   32'hFF);
    check("rst_err",     {31'b0, o_err},     0);

    // Latency: the accept edge loads S1, the next edge loads S2.
    @(posedge clk); #1;
    send(3);
    check("lat_vld_s1", {31'b0, o_out_vld}, 0);
    @(posedge clk); #1;
    check("lat_vld_s2", {31'b0, o_out_vld}, 1);
    check("lat_x",      {24'b0, o_out_x},   32'h07);
    check("lat_x_c",    {24'b0, c_out_x},   32'hF8);
    drain();

    // Back-to-back stream 1..7, no bubbles.
    out_cyc.delete();
    for (int n = 1; n < W; n++) send(n);
    drain();
    check("stream_count", 32'(out_cyc.size()), 7);
    if (out_cyc.size() == 7) check("stream_no_bubble", 32'(out_cyc[6] - out_cyc[0]), 6);

    // Illegal counts dropped with o_err; only N=2 emitted.
    err_seen = 0; exp_err = 0;
    send(0); send(8); send(2);
    drain();
    check("err_pulses", 32'(err_seen), 32'(exp_err));
    check("err_pulses_abs", 32'(err_seen), 2);
`ifdef C_UNARY_ENC_ERR_CNT_EN
    check("err_cnt",   {16'b0, o_err_cnt}, 2);
    check("err_cnt_c", {16'b0, c_err_cnt}, 2);
`endif

    // Stall: output blocked, two accepts fill the pipe, then release.
    i_out_rdy = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int n = 1; n < W; n++) send(n);
      end
    join_none
    begin
      int k = 0;
      while (acc_cnt < 2 && k < 50) begin @(posedge clk); k++; end
      check("stall_accepts", 32'(acc_cnt), 2);
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_in_rdy", {31'b0, o_in_rdy},  0);
      check("stall_vld",    {31'b0, o_out_vld}, 1);
      check("stall_x",      {24'b0, o_out_x},   32'h01);
    end
    check("stall_accepts_held", 32'(acc_cnt), 2);
    @(posedge clk); #1 i_out_rdy = 1'b1;
    begin
      int k = 0;
      while (acc_cnt < 7 && k < 50) begin @(posedge clk); k++; end
      check("stall_all_accepted", 32'(acc_cnt), 7);
    end
    drain();

    // Reset with both stages full: held counts vanish.
    i_out_rdy = 1'b0;
    send(4); send(5);
    @(negedge clk);
    check("full_in_rdy", {31'b0, o_in_rdy}, 0);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_vld", {31'b0, o_out_vld}, 0);
    check("mid_rst_in_rdy",  {31'b0, o_in_rdy},  1);
    check("mid_rst_err",     {31'b0, o_err},     0);
`ifdef C_UNARY_ENC_ERR_CNT_EN
    check("mid_rst_err_cnt", {16'b0, o_err_cnt}, 0);
`endif
    @(posedge clk); #1 i_out_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_output", {31'b0, o_out_vld}, 0);
    send(6);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
